// File: rtl/blink_pkg.sv
// ============================================================================
// blink_pkg : shared state encoding and timer sizing for blink_driver
// Revision  : 1.0
// ============================================================================
`default_nettype none

package blink_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ON   = 2'd1;
  localparam logic [1:0] ST_OFF  = 2'd2;

  // Wide enough to hold max(on_t, off_t) - 1 as a load value.
  function automatic int timer_width(input int on_t, input int off_t);
    int m;
    m = (on_t > off_t) ? on_t : off_t;
    return $clog2(m + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/blink_driver_cycle_timer.sv
// ============================================================================
// cycle_timer : loadable down-counter with zero flag, holds at zero
// Revision    : 1.0
// ============================================================================
`default_nettype none

module cycle_timer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  output logic             zero_o
);

  logic [WIDTH-1:0] count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= load_val_i;
    end else if (count_q != '0) begin
      count_q <= count_q - WIDTH'(1);
    end
  end

  assign zero_o = (count_q == '0);

endmodule

`default_nettype wire

// File: rtl/blink_driver.sv
// ============================================================================
// blink_driver : turns a trigger pulse into N timed blinks with busy/done
// Revision     : 1.0
// ============================================================================
`default_nettype none

module blink_driver
  import blink_pkg::*;
#(
  parameter int ON_TIME  = 5000,
  parameter int OFF_TIME = 5000,
  parameter int CNT_W    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             trig,
  input  logic [CNT_W-1:0] num,
  output logic             led,
  output logic             busy,
  output logic             done
);

  localparam int            TW       = timer_width(ON_TIME, OFF_TIME);
  localparam logic [TW-1:0] ON_LOAD  = TW'(ON_TIME - 1);
  localparam logic [TW-1:0] OFF_LOAD = TW'(OFF_TIME - 1);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] remaining_q, remaining_d;
  logic             led_q, busy_q, done_q, done_d;
  logic             tmr_load;
  logic [TW-1:0]    tmr_val;
  logic             tmr_zero;

  cycle_timer #(
    .WIDTH (TW)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .zero_o     (tmr_zero)
  );

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    done_d      = 1'b0;
    tmr_load    = 1'b0;
    tmr_val     = ON_LOAD;
    case (state_q)
      ST_IDLE: begin
        if (trig && (num != '0)) begin
          state_d     = ST_ON;
          remaining_d = num;
          tmr_load    = 1'b1;
          tmr_val     = ON_LOAD;
        end
      end
      ST_ON: begin
        if (tmr_zero) begin
          // Last blink ends straight into IDLE with no trailing OFF gap.
          if (remaining_q == CNT_W'(1)) begin
            state_d     = ST_IDLE;
            remaining_d = '0;
            done_d      = 1'b1;
          end else begin
            state_d     = ST_OFF;
            remaining_d = remaining_q - CNT_W'(1);
            tmr_load    = 1'b1;
            tmr_val     = OFF_LOAD;
          end
        end
      end
      ST_OFF: begin
        if (tmr_zero) begin
          state_d  = ST_ON;
          tmr_load = 1'b1;
          tmr_val  = ON_LOAD;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        remaining_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      remaining_q <= '0;
      led_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      led_q       <= (state_d == ST_ON);
      busy_q      <= (state_d != ST_IDLE);
      done_q      <= done_d;
    end
  end

  assign led  = led_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

`default_nettype wire
